imem_arbiter: RTL
=================

# imem_arbiter

Two-port arbiter that shares the single-read-port instruction memory between the CPU fetch path and the debug/loader port. It accepts one read per cycle using a round-robin policy with a debug lock for burst access, registers the memory address and read-enable, and returns the negedge-captured instruction word to the winning requester. It sits between the fetch stage, the debug port and the instruction memory.

## Interface
- ADDR_W, 10, word address width, matching the instruction memory address
- DATA_W, 16, instruction width
- clk  in  1  system clock; all state updates on posedge
- rst_n  in  1  synchronous active-low reset
- f_req  in  1  fetch read request; f_addr is valid while high
- f_addr  in  ADDR_W  fetch word address
- f_gnt  out  1  combinational; high means fetch request accepted at the next posedge
- f_rvalid  out  1  registered one-cycle pulse; f_rdata valid
- f_rdata  out  DATA_W  fetch read data
- d_req  in  1  debug read request
- d_addr  in  ADDR_W  debug word address
- d_lock  in  1  debug burst lock request
- d_gnt  out  1  combinational debug accept
- d_rvalid  out  1  registered debug data-valid pulse
- d_rdata  out  DATA_W  debug read data
- mem_rd_en  out  1  registered read enable to instruction memory
- mem_addr  out  ADDR_W  registered address to instruction memory
- mem_instr  in  DATA_W  memory output, updated on negedge clk when mem_rd_en is high

## Operation
- FSM states: PRI_F (fetch wins ties), PRI_D (debug wins ties), LOCKED (debug exclusive). Reset state PRI_F.
- PRI_F: f_req wins if high; otherwise d_req wins. Grant to fetch leads to PRI_D; grant to debug leads to PRI_F, or to LOCKED if d_lock is high.
- PRI_D: mirrors PRI_F with debug winning ties. A debug grant with d_lock high leads to LOCKED.
- LOCKED: f_gnt is forced to 0. d_gnt equals d_req. The FSM leaves for PRI_F when d_lock is sampled low, with fetch favoured next. A grant in that same cycle is still allowed.
- No request means no grant, mem_rd_en goes to 0 next cycle, mem_addr holds its value, and the state is unchanged.
- At most one of f_gnt or d_gnt is high in any cycle.
- A 1-bit tag (winner) and a valid bit pipeline alongside each read. The returned word is steered only to the tagged port.
- f_rdata and d_rdata hold their last value while the matching rvalid is low.
- There is no backpressure on the return path. Requesters must accept rvalid.

## Timing
- Cycle N: req high and gnt high (combinational).
- Posedge ending N: mem_rd_en is set to 1 and mem_addr to the winner's address. Both are valid throughout N+1.
- Negedge in N+1: memory captures mem[mem_addr] onto mem_instr.
- Posedge ending N+1: mem_instr and the tag are registered. The port's rvalid is high with rdata during N+2.
- Fixed latency is 2 cycles from grant to rvalid. Throughput is 1 read per cycle, and back-to-back grants give back-to-back rvalids in order.
- A requester may change addr, or hold req for a new read, on the posedge after gnt. A req without gnt must keep addr stable.
- Reset, when rst_n is sampled low:
  - mem_rd_en=0, mem_addr=0, f_rvalid=0, d_rvalid=0, f_rdata=0, d_rdata=0, state PRI_F.
  - Reads in flight are discarded, so no rvalid fires for them.
  - f_gnt and d_gnt are 0 while rst_n is low.
- Simultaneous d_lock rise and f_req in PRI_F: fetch wins, and lock takes effect only on the next debug grant.
- Address wrap is not applied. The address passes through unmodified at ADDR_W bits.

## Test plan
- Single fetch: f_req=1, f_addr=0x005 for 1 cycle, with mem[5]=0xA5A5 preloaded. Required: f_gnt the same cycle, mem_rd_en=1 and mem_addr=0x005 the next cycle, f_rvalid with f_rdata=0xA5A5 two cycles after the grant, and d_rvalid stays 0.
- Contention: f_req and d_req held high for 4 cycles with addrs 0x010 and 0x020 from PRI_F. Required grants F,D,F,D and rvalids in the same order with the correct data.
- Lock: d_req=1, d_lock=1 for 3 cycles with f_req=1 throughout. Required: f_gnt=0 for all 3 debug grants, d_lock drops, and fetch is granted in the following cycle.
- Streaming: f_req held for 8 cycles with incrementing addresses 0x3F8–0x3FF. Required: 8 consecutive f_rvalid pulses with matching data and no bubbles.
- Reset mid-flight: grant a fetch, then assert rst_n=0 in the next cycle. Required: no f_rvalid, all outputs at their reset values, and after release a tie resolves to fetch.
- Idle: no requests for 5 cycles. Required: mem_rd_en=0, mem_addr holds its last value, no rvalid, and rdata holds its last value.

Source files
------------

// File: rtl/imem_arbiter.sv
// rtl/imem_arbiter.sv - two-port round-robin arbiter for the instruction memory read port
//
// Shares one instruction-memory read port between the CPU fetch path (f_*)
// and the debug/loader port (d_*). One read is accepted per cycle and data
// returns two cycles after the grant to whichever port won.
//
// Ports:
//   clk_i, rst_n_i              clock, synchronous active-low reset
//   f_req_i, f_addr_i           fetch request and word address
//   f_gnt_o                     fetch accepted at the next posedge (combinational)
//   f_rvalid_o, f_rdata_o       fetch read-data pulse and data
//   d_req_i, d_addr_i, d_lock_i debug request, word address, burst lock
//   d_gnt_o                     debug accepted at the next posedge (combinational)
//   d_rvalid_o, d_rdata_o       debug read-data pulse and data
//   mem_rd_en_o, mem_addr_o     registered read enable and address to memory
//   mem_instr_i                 memory output, updated on negedge when read-enabled
module imem_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              f_req_i,
  input  logic [ADDR_W-1:0] f_addr_i,
  output logic              f_gnt_o,
  output logic              f_rvalid_o,
  output logic [DATA_W-1:0] f_rdata_o,
  input  logic              d_req_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic              d_lock_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              mem_rd_en_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [DATA_W-1:0] mem_instr_i
);

  typedef enum logic [1:0] {
    PRI_F  = 2'b00,
    PRI_D  = 2'b01,
    LOCKED = 2'b10
  } state_e;

  state_e state_q, state_d;

  logic              f_gnt, d_gnt;
  logic              mem_rd_en_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              tag_q;        // 1: read in memory stage belongs to debug
  logic              f_rvalid_q, d_rvalid_q;
  logic [DATA_W-1:0] f_rdata_q, d_rdata_q;

  always_comb begin
    f_gnt   = 1'b0;
    d_gnt   = 1'b0;
    state_d = state_q;

    if (rst_n_i) begin
      case (state_q)
        PRI_D: begin
          d_gnt = d_req_i;
          f_gnt = f_req_i & ~d_req_i;
        end
        LOCKED: begin
          d_gnt = d_req_i;
        end
        default: begin
          f_gnt = f_req_i;
          d_gnt = d_req_i & ~f_req_i;
        end
      endcase

      case (state_q)
        LOCKED: begin
          // Leaving the lock still lets this cycle's debug grant through;
          // fetch gets priority afterwards.
          if (!d_lock_i) state_d = PRI_F;
        end
        PRI_F, PRI_D: begin
          if (f_gnt)      state_d = PRI_D;
          else if (d_gnt) state_d = d_lock_i ? LOCKED : PRI_F;
        end
        default: state_d = PRI_F;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= PRI_F;
      mem_rd_en_q <= 1'b0;
      mem_addr_q  <= '0;
      tag_q       <= 1'b0;
      f_rvalid_q  <= 1'b0;
      d_rvalid_q  <= 1'b0;
      f_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      mem_rd_en_q <= f_gnt | d_gnt;
      tag_q       <= d_gnt;
      // Address holds while idle so the memory sees a stable bus.
      if (f_gnt)      mem_addr_q <= f_addr_i;
      else if (d_gnt) mem_addr_q <= d_addr_i;

      // mem_instr_i was refreshed on the negedge inside the memory cycle.
      f_rvalid_q <= mem_rd_en_q & ~tag_q;
      d_rvalid_q <= mem_rd_en_q &  tag_q;
      if (mem_rd_en_q && !tag_q) f_rdata_q <= mem_instr_i;
      if (mem_rd_en_q &&  tag_q) d_rdata_q <= mem_instr_i;
    end
  end

  assign f_gnt_o     = f_gnt;
  assign d_gnt_o     = d_gnt;
  assign mem_rd_en_o = mem_rd_en_q;
  assign mem_addr_o  = mem_addr_q;
  assign f_rvalid_o  = f_rvalid_q;
  assign d_rvalid_o  = d_rvalid_q;
  assign f_rdata_o   = f_rdata_q;
  assign d_rdata_o   = d_rdata_q;

endmodule
